// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage hazard controller:
// immediate types, RV32I base opcodes and FSM states.
package decode_hazard_ctrl_pkg;

   localparam logic [2:0] RTYPE = 3'd0;
   localparam logic [2:0] ITYPE = 3'd1;
   localparam logic [2:0] STYPE = 3'd2;
   localparam logic [2:0] BTYPE = 3'd3;
   localparam logic [2:0] UTYPE = 3'd4;
   localparam logic [2:0] JTYPE = 3'd5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LDSTALL  = 2'd1,
      REDIRECT = 2'd2
   } state_t;

endpackage

// File: rtl/decode_hazard_ctrl_opcode_classifier.sv
// Combinational opcode classifier: immediate type, illegal
// opcode flag and source-register usage for the ID stage.
module opcode_classifier
   import decode_hazard_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic       i_valid,
   output logic [2:0] o_imm_type,
   output logic       o_illegal,
   output logic       o_uses_rs1,
   output logic       o_uses_rs2
);

   logic [2:0] w_imm;
   logic       w_known;
   logic       w_rs1;
   logic       w_rs2;

   always_comb begin
      w_imm   = RTYPE;
      w_known = 1'b1;
      w_rs1   = 1'b1;
      w_rs2   = 1'b0;
      case (i_opcode)
         OPC_LUI, OPC_AUIPC: begin
            w_imm = UTYPE;
            w_rs1 = 1'b0;
         end
         OPC_JAL: begin
            w_imm = JTYPE;
            w_rs1 = 1'b0;
         end
         OPC_JALR, OPC_LOAD, OPC_OPIMM: w_imm = ITYPE;
         OPC_STORE: begin
            w_imm = STYPE;
            w_rs2 = 1'b1;
         end
         OPC_BRANCH: begin
            w_imm = BTYPE;
            w_rs2 = 1'b1;
         end
         OPC_OP:  w_rs2 = 1'b1;
         default: w_known = 1'b0;
      endcase
   end

   assign o_imm_type = w_imm;
   assign o_illegal  = i_valid & ~w_known;
   assign o_uses_rs1 = i_valid & w_rs1;
   assign o_uses_rs2 = i_valid & w_rs2;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls and redirect flushes.
// Optional performance counters are built with PERF_CNT_EN.
module decode_hazard_ctrl
   import decode_hazard_ctrl_pkg::*;
(
   input  logic        CPU_CLK,
   input  logic        CPU_RST,
   input  logic [31:0] InstD,
   input  logic        ValidD,
   input  logic        MemReadE,
   input  logic [4:0]  RdE,
   input  logic        RedirectE,
   output logic [2:0]  ImmTypeD,
   output logic        IllegalD,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushD,
   output logic        FlushE,
   output logic [31:0] StallCnt,
   output logic [31:0] FlushCnt
);

   state_t r_state;
   state_t w_next;
   logic   w_uses_rs1;
   logic   w_uses_rs2;
   logic   w_load_use;
   logic   w_stall;
   logic   w_flush_d;
   logic   w_flush_e;
   logic   w_unused;

   assign w_unused = ^{InstD[31:25], InstD[14:7]};

   opcode_classifier u_cls (
      .i_opcode   (InstD[6:0]),
      .i_valid    (ValidD),
      .o_imm_type (ImmTypeD),
      .o_illegal  (IllegalD),
      .o_uses_rs1 (w_uses_rs1),
      .o_uses_rs2 (w_uses_rs2)
   );

   assign w_load_use = MemReadE && (RdE != 5'd0) &&
      ((w_uses_rs1 && (RdE == InstD[19:15])) ||
       (w_uses_rs2 && (RdE == InstD[24:20])));

   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) r_state <= RUN;
      else         r_state <= w_next;
   end

   // Redirect always wins over a load-use hazard.
   always_comb begin
      w_next    = RUN;
      w_stall   = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      unique case (r_state)
         RUN: begin
            if (RedirectE) begin
               w_flush_d = 1'b1;
               w_flush_e = 1'b1;
               w_next    = REDIRECT;
            end else if (w_load_use) begin
               w_stall   = 1'b1;
               w_flush_e = 1'b1;
               w_next    = LDSTALL;
            end
         end
         LDSTALL: begin
            if (RedirectE) begin
               w_flush_d = 1'b1;
               w_flush_e = 1'b1;
               w_next    = REDIRECT;
            end else begin
               w_stall   = 1'b1;
               w_flush_e = 1'b1;
            end
         end
         REDIRECT: begin
            w_flush_d = 1'b1;
            if (RedirectE) begin
               w_flush_e = 1'b1;
               w_next    = REDIRECT;
            end
         end
         default: w_next = RUN;
      endcase
      if (CPU_RST) begin
         w_next    = RUN;
         w_stall   = 1'b0;
         w_flush_d = 1'b0;
         w_flush_e = 1'b0;
      end
   end

   assign StallF = w_stall;
   assign StallD = w_stall;
   assign FlushD = w_flush_d;
   assign FlushE = w_flush_e;

`ifdef PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) begin
         r_stall_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
      end else begin
         if (w_stall && (r_stall_cnt != 32'hFFFFFFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if ((w_flush_d || w_flush_e) &&
             (r_flush_cnt != 32'hFFFFFFFF))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign StallCnt = r_stall_cnt;
   assign FlushCnt = r_flush_cnt;
`else
   assign StallCnt = 32'd0;
   assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: vector table
// plus directed multi-cycle sequences.
module tb_decode_hazard_ctrl;

   logic        CPU_CLK = 1'b0;
   logic        CPU_RST = 1'b1;
   logic [31:0] InstD = 32'h0;
   logic        ValidD = 1'b0;
   logic        MemReadE = 1'b0;
   logic [4:0]  RdE = 5'd0;
   logic        RedirectE = 1'b0;
   logic [2:0]  ImmTypeD;
   logic        IllegalD;
   logic        StallF, StallD, FlushD, FlushE;
   logic [31:0] StallCnt, FlushCnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 CPU_CLK = ~CPU_CLK;

   decode_hazard_ctrl dut (
      .CPU_CLK   (CPU_CLK),
      .CPU_RST   (CPU_RST),
      .InstD     (InstD),
      .ValidD    (ValidD),
      .MemReadE  (MemReadE),
      .RdE       (RdE),
      .RedirectE (RedirectE),
      .ImmTypeD  (ImmTypeD),
      .IllegalD  (IllegalD),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .StallCnt  (StallCnt),
      .FlushCnt  (FlushCnt)
   );

   typedef struct {
      logic [31:0] inst;
      logic        valid;
      logic        memr;
      logic [4:0]  rd;
      logic        redir;
      logic [2:0]  imm;
      logic        ill;
      logic [3:0]  ctrl;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_ctrl(input string nm, input logic [3:0] exp);
      chk(nm, {28'd0, StallF, StallD, FlushD, FlushE}, {28'd0, exp});
   endtask

   task automatic next_cyc();
      @(posedge CPU_CLK);
      #1;
   endtask

   task automatic drive(input logic [31:0] inst, input logic v,
                        input logic mr, input logic [4:0] rd,
                        input logic rdr);
      InstD = inst;
      ValidD = v;
      MemReadE = mr;
      RdE = rd;
      RedirectE = rdr;
   endtask

   task automatic do_reset();
      CPU_RST = 1'b1;
      drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      next_cyc();
      CPU_RST = 1'b0;
   endtask

   localparam logic [31:0] ADD356 = 32'h006281B3;

   initial begin
      tbl[0]  = '{32'h00500093, 1, 0, 5'd0, 0, 3'd1, 0, 4'b0000};
      tbl[1]  = '{32'h00112623, 1, 0, 5'd0, 0, 3'd2, 0, 4'b0000};
      tbl[2]  = '{32'h00208463, 1, 0, 5'd0, 0, 3'd3, 0, 4'b0000};
      tbl[3]  = '{32'h123450B7, 1, 0, 5'd0, 0, 3'd4, 0, 4'b0000};
      tbl[4]  = '{32'h008000EF, 1, 0, 5'd0, 0, 3'd5, 0, 4'b0000};
      tbl[5]  = '{32'h002081B3, 1, 0, 5'd0, 0, 3'd0, 0, 4'b0000};
      tbl[6]  = '{32'h0000007F, 1, 0, 5'd0, 0, 3'd0, 1, 4'b0000};
      tbl[7]  = '{32'h0000007F, 0, 0, 5'd0, 0, 3'd0, 0, 4'b0000};
      tbl[8]  = '{ADD356,       1, 1, 5'd5, 0, 3'd0, 0, 4'b1101};
      tbl[9]  = '{ADD356,       1, 1, 5'd6, 0, 3'd0, 0, 4'b1101};
      tbl[10] = '{32'h000001B3, 1, 1, 5'd0, 0, 3'd0, 0, 4'b0000};
      tbl[11] = '{32'h123451B7, 1, 1, 5'd3, 0, 3'd4, 0, 4'b0000};
      tbl[12] = '{32'h00112623, 1, 1, 5'd1, 0, 3'd2, 0, 4'b1101};
      tbl[13] = '{32'h00500093, 1, 1, 5'd5, 0, 3'd1, 0, 4'b0000};
      tbl[14] = '{ADD356,       1, 1, 5'd5, 1, 3'd0, 0, 4'b0011};
      tbl[15] = '{ADD356,       0, 1, 5'd5, 0, 3'd0, 0, 4'b0000};
      tbl[16] = '{32'h00208463, 1, 1, 5'd2, 0, 3'd3, 0, 4'b1101};

      // Reset: controls held low even with redirect requested
      CPU_RST = 1'b1;
      next_cyc();
      drive(ADD356, 1'b1, 1'b1, 5'd5, 1'b1);
      #2;
      chk_ctrl("reset_ctrl", 4'b0000);
      next_cyc();
      chk("reset_stallcnt", StallCnt, 32'd0);
      chk("reset_flushcnt", FlushCnt, 32'd0);
      drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0);

      for (int i = 0; i < 17; i++) begin
         do_reset();
         drive(tbl[i].inst, tbl[i].valid, tbl[i].memr,
               tbl[i].rd, tbl[i].redir);
         #2;
         chk($sformatf("v%0d_imm", i), {29'd0, ImmTypeD},
             {29'd0, tbl[i].imm});
         chk($sformatf("v%0d_ill", i), {31'd0, IllegalD},
             {31'd0, tbl[i].ill});
         chk_ctrl($sformatf("v%0d_ctrl", i), tbl[i].ctrl);
      end

      // Load-use: two stall cycles then idle; counters start clean
      do_reset();
      drive(ADD356, 1'b1, 1'b1, 5'd5, 1'b0);
      #2 chk_ctrl("lu_c1", 4'b1101);
      next_cyc();
      MemReadE = 1'b0;
      #2 chk_ctrl("lu_c2", 4'b1101);
      next_cyc();
      #2 chk_ctrl("lu_c3", 4'b0000);
`ifdef PERF_CNT_EN
      chk("lu_stallcnt", StallCnt, 32'd2);
      chk("lu_flushcnt", FlushCnt, 32'd2);
`else
      chk("lu_stallcnt", StallCnt, 32'd0);
      chk("lu_flushcnt", FlushCnt, 32'd0);
`endif

      // Redirect with simultaneous load-use
      do_reset();
      drive(ADD356, 1'b1, 1'b1, 5'd5, 1'b1);
      #2 chk_ctrl("rd_c1", 4'b0011);
      next_cyc();
      drive(ADD356, 1'b1, 1'b0, 5'd0, 1'b0);
      #2 chk_ctrl("rd_c2", 4'b0010);
      next_cyc();
      #2 chk_ctrl("rd_c3", 4'b0000);

      // Redirect arriving during LDSTALL
      do_reset();
      drive(ADD356, 1'b1, 1'b1, 5'd5, 1'b0);
      #2 chk_ctrl("lr_c1", 4'b1101);
      next_cyc();
      drive(ADD356, 1'b1, 1'b0, 5'd0, 1'b1);
      #2 chk_ctrl("lr_c2", 4'b0011);
      next_cyc();
      RedirectE = 1'b0;
      #2 chk_ctrl("lr_c3", 4'b0010);
      next_cyc();
      #2 chk_ctrl("lr_c4", 4'b0000);

      // Back-to-back redirects stay in REDIRECT
      do_reset();
      drive(ADD356, 1'b1, 1'b0, 5'd0, 1'b1);
      #2 chk_ctrl("rr_c1", 4'b0011);
      next_cyc();
      #2 chk_ctrl("rr_c2", 4'b0011);
      next_cyc();
      RedirectE = 1'b0;
      #2 chk_ctrl("rr_c3", 4'b0010);
      next_cyc();
      #2 chk_ctrl("rr_c4", 4'b0000);

      // Reset in LDSTALL abandons the sequence
      do_reset();
      drive(ADD356, 1'b1, 1'b1, 5'd5, 1'b0);
      #2 chk_ctrl("rl_c1", 4'b1101);
      next_cyc();
      MemReadE = 1'b0;
      CPU_RST = 1'b1;
      #2 chk_ctrl("rl_rst", 4'b0000);
      next_cyc();
      CPU_RST = 1'b0;
      #2 chk_ctrl("rl_after", 4'b0000);
      chk("rl_stallcnt", StallCnt, 32'd0);
      chk("rl_flushcnt", FlushCnt, 32'd0);

`ifdef PERF_CNT_EN
      // Stall counter saturation
      do_reset();
      force dut.r_stall_cnt = 32'hFFFFFFFE;
      #1 release dut.r_stall_cnt;
      drive(ADD356, 1'b1, 1'b1, 5'd5, 1'b0);
      next_cyc();
      MemReadE = 1'b0;
      #2 chk("sat_c1", StallCnt, 32'hFFFFFFFF);
      next_cyc();
      #2 chk("sat_c2", StallCnt, 32'hFFFFFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
